// File: rtl/mul_div_unit.sv
// Multi-cycle radix-2 multiply/divide unit with HI/LO result registers.
// A start in IDLE runs WIDTH iterations, then sign-corrects and writes hi/lo in FIN.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic [WIDTH-1:0] writeData,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic                 div_q, div_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic                 dz_q, dz_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 sgn;
  logic [WIDTH-1:0]     absA, absB;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_shift, div_trial;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;

  // Unsigned magnitudes are exact even for the most-negative value (2^(WIDTH-1)).
  assign sgn  = ~op[0];
  assign absA = (sgn && opA[WIDTH-1]) ? -opA : opA;
  assign absB = (sgn && opB[WIDTH-1]) ? -opB : opB;

  // acc holds {partial product, multiplier} or {partial remainder, quotient/dividend}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, m_q};
  assign div_next  = div_trial[WIDTH]
                   ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                   : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Divide-by-zero leaves the dividend magnitude as remainder; re-signing restores opA.
  assign prod = negq_q ? -acc_q : acc_q;
  assign quot = dz_q ? '1 : (negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
  assign rem  = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (writeHi) hi_d = writeData;
        if (writeLo) lo_d = writeData;
        if (start) begin
          div_d   = op[1];
          negq_d  = sgn & (opA[WIDTH-1] ^ opB[WIDTH-1]);
          negr_d  = sgn & opA[WIDTH-1];
          dz_d    = op[1] & (opB == '0);
          m_d     = op[1] ? absB : absA;
          acc_d   = {{WIDTH{1'b0}}, (op[1] ? absA : absB)};
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FIN;
      end
      S_FIN: begin
        hi_d    = div_q ? rem  : prod[2*WIDTH-1:WIDTH];
        lo_d    = div_q ? quot : prod[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit (WIDTH=32 and WIDTH=8) with a result scoreboard.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start32 = 1'b0, wHi32 = 1'b0, wLo32 = 1'b0;
  logic [1:0]  op32 = 2'b00;
  logic [31:0] a32 = '0, b32 = '0, wd32 = '0;
  logic [31:0] hi32, lo32;
  logic        busy32, done32;

  logic        start8 = 1'b0, wHi8 = 1'b0, wLo8 = 1'b0;
  logic [1:0]  op8 = 2'b00;
  logic [7:0]  a8 = '0, b8 = '0, wd8 = '0;
  logic [7:0]  hi8, lo8;
  logic        busy8, done8;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] sb32[$];
  logic [15:0] sb8[$];

  mul_div_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op32), .opA(a32), .opB(b32),
    .writeHi(wHi32), .writeLo(wLo32), .writeData(wd32),
    .hi(hi32), .lo(lo32), .busy(busy32), .done(done32)
  );

  mul_div_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .opA(a8), .opB(b8),
    .writeHi(wHi8), .writeLo(wLo8), .writeData(wd8),
    .hi(hi8), .lo(lo8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results from native 64-bit arithmetic.
  function automatic logic [63:0] model32(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint x, y, q, r;
    x = op[0] ? longint'(a) : longint'($signed(a));
    y = op[0] ? longint'(b) : longint'($signed(b));
    if (!op[1]) return 64'(x * y);
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a negedge; returns at the negedge of the first busy cycle.
  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit push);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    if (push) sb32.push_back(exp);
    @(negedge clk);
    start32 = 1'b0;
  endtask

  task automatic wait32(input string tag, input int already);
    int n;
    logic [63:0] exp;
    n = already;
    while (busy32 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 64'(n), 64'd33);
    chk({tag, " done"}, 64'(done32), 64'd1);
    exp = (sb32.size() != 0) ? sb32.pop_front() : 'x;
    chk({tag, " hi:lo"}, {hi32, lo32}, exp);
  endtask

  task automatic wait8(input string tag);
    int n;
    logic [15:0] exp;
    n = 0;
    while (busy8 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy cycles"}, 64'(n), 64'd9);
    chk({tag, " done"}, 64'(done8), 64'd1);
    exp = (sb8.size() != 0) ? sb8.pop_front() : 'x;
    chk({tag, " hi:lo"}, 64'({hi8, lo8}), 64'(exp));
  endtask

  initial begin
    bit seen_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    #2 rst = 1'b1;
    #2;
    chk("reset hi", 64'(hi32), 64'd0);
    chk("reset lo", 64'(lo32), 64'd0);
    chk("reset busy", 64'(busy32), 64'd0);
    chk("reset done", 64'(done32), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue32(2'b00, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1}, 1'b1);
    wait32("MULT -3*5", 0);
    @(negedge clk);
    chk("done one cycle", 64'(done32), 64'd0);

    issue32(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b1);
    wait32("MULTU max*max", 0);
    chk("busy low in done cycle", 64'(busy32), 64'd0);
    issue32(2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    chk("back-to-back accepted", 64'(busy32), 64'd1);
    wait32("DIV -7/2", 0);

    @(negedge clk);
    issue32(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 1'b1);
    wait32("DIV min/-1", 0);

    @(negedge clk);
    issue32(2'b11, 32'd10, 32'd0, {32'h0000_000A, 32'hFFFF_FFFF}, 1'b1);
    repeat (5) @(negedge clk);
    start32 = 1'b1; op32 = 2'b01; a32 = 32'd3; b32 = 32'd3;
    wLo32 = 1'b1; wd32 = 32'h1234;
    @(negedge clk);
    start32 = 1'b0; wLo32 = 1'b0;
    wait32("DIVU 10/0", 6);
    @(negedge clk);
    chk("ignored start not queued", 64'(busy32), 64'd0);

    issue32(2'b10, 32'hFFFF_FFF9, 32'd0, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1'b1);
    wait32("DIV -7/0", 0);
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'($urandom_range(1, 9)) : $urandom;
      issue32(rop, ra, rb, model32(rop, ra, rb), 1'b1);
      wait32("random op", 0);
      @(negedge clk);
    end

    wHi32 = 1'b1; wd32 = 32'hCAFE_0001;
    @(negedge clk);
    wHi32 = 1'b0;
    chk("MTHI hi", 64'(hi32), 64'hCAFE_0001);
    wLo32 = 1'b1; wd32 = 32'h0BAD_F00D;
    @(negedge clk);
    wLo32 = 1'b0;
    chk("MTLO lo", 64'(lo32), 64'h0BAD_F00D);
    chk("MTLO keeps hi", 64'(hi32), 64'hCAFE_0001);

    wHi32 = 1'b1; wd32 = 32'h0000_DEAD;
    issue32(2'b01, 32'd7, 32'd6, {32'd0, 32'd42}, 1'b1);
    wHi32 = 1'b0;
    chk("start+MTHI write now", 64'(hi32), 64'h0000_DEAD);
    wait32("MULTU 7*6 over MTHI", 0);
    @(negedge clk);

    issue32(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0, 1'b0);
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst busy", 64'(busy32), 64'd0);
    chk("async rst done", 64'(done32), 64'd0);
    chk("async rst hi", 64'(hi32), 64'd0);
    chk("async rst lo", 64'(lo32), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done32 || busy32) seen_done = 1'b1;
    end
    chk("no activity after rst", 64'(seen_done), 64'd0);

    start8 = 1'b1; op8 = 2'b00; a8 = 8'h80; b8 = 8'h80;
    sb8.push_back({8'h40, 8'h00});
    @(negedge clk);
    start8 = 1'b0;
    wait8("W8 MULT min*min");
    @(negedge clk);

    start8 = 1'b1; op8 = 2'b10; a8 = 8'h80; b8 = 8'hFF;
    sb8.push_back({8'h00, 8'h80});
    @(negedge clk);
    start8 = 1'b0;
    wait8("W8 DIV min/-1");
    @(negedge clk);

    wHi8 = 1'b1; wLo8 = 1'b1; wd8 = 8'hA5;
    @(negedge clk);
    wHi8 = 1'b0; wLo8 = 1'b0;
    chk("W8 MTHI+MTLO", 64'({hi8, lo8}), 64'h0000_0000_0000_A5A5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
